mem_arbiter: RTL and testbench

Parametrised N-master memory arbiter that shares one RAM controller port and one UART port among several requesters. Typical requesters are the CPU instruction fetch and data access, plus a future DMA or debug master. It replaces the fixed two-port mem_control/mmu pairing. It performs address decode (RAM / serial data / serial status), round-robin or fixed-priority arbitration, a configurable RAM wait count, and serial completion handshakes with a timeout. Each master gets a per-master stall signal that drives pipeline pause.

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM controller port and one UART port among NUM_M
// requesters (instruction fetch, data access, DMA/debug, ...).
//
// Each master raises req_i and holds it until it sees its one-cycle ack_o.
// The winner's we/addr/wdata are latched when it is granted. The latched
// address is then decoded into one of three targets:
//   - serial status register: answered immediately, with no bus activity;
//   - serial data register: one serial start pulse, then wait for the
//     matching completion flag, bounded by a timeout;
//   - anything else: a RAM access with a fixed wait count.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   req_i/we_i [NUM_M]        per-master request and write flag
//   addr_i, wdata_i           flattened per-master address / write data
//   rdata_o                   read data, valid while ack_o is high, then held
//   ack_o [NUM_M]             one-hot completion pulse
//   stall_o [NUM_M]           req_i & ~ack_o, drives pipeline pause
//   err_o                     sticky serial-timeout flag
//   ram_*                     RAM controller port
//   serial_*                  UART port and its completion flags
module mem_arbiter #(
  parameter int                NUM_M         = 2,
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 18,
  parameter int                ARB_MODE      = 0,
  parameter int                RAM_WAIT      = 2,
  parameter logic [ADDR_W-1:0] SER_DATA_ADDR = 18'h0BF00,
  parameter logic [ADDR_W-1:0] SER_STAT_ADDR = 18'h0BF01,
  parameter int                SER_TIMEOUT   = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          req_i,
  input  logic [NUM_M-1:0]          we_i,
  input  logic [NUM_M*ADDR_W-1:0]   addr_i,
  input  logic [NUM_M*DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [NUM_M-1:0]          ack_o,
  output logic [NUM_M-1:0]          stall_o,
  output logic                      err_o,
  output logic                      ram_enable_o,
  output logic                      ram_readWrite_o,
  output logic [ADDR_W-1:0]         ram_address_o,
  output logic [DATA_W-1:0]         ram_dataWrite_o,
  input  logic [DATA_W-1:0]         ram_dataRead_i,
  output logic                      serial_enable_o,
  output logic                      serial_readWrite_o,
  output logic [DATA_W-1:0]         serial_dataWrite_o,
  input  logic [DATA_W-1:0]         serial_dataRead_i,
  input  logic                      serial_sendComplete_i,
  input  logic                      serial_receiveComplete_i
);

  localparam int IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CNT_MAX = (SER_TIMEOUT > RAM_WAIT) ? SER_TIMEOUT : RAM_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RAM      = 3'd1;
  localparam logic [2:0] S_SER_GO   = 3'd2;
  localparam logic [2:0] S_SER_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        state;
  logic [IDX_W-1:0]  win_q;
  logic [IDX_W-1:0]  ptr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;

  logic [IDX_W-1:0]  win;
  logic              found;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [IDX_W-1:0]  next_ptr;
  logic [NUM_M-1:0]  win_onehot;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rx_word;
  logic              ser_flag;
  logic              unused_rx_hi;

  // Winner search. Round-robin starts at the pointer and wraps upward;
  // fixed priority always starts at index 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_M; j++) begin
      int c;
      c = j;
      if (ARB_MODE == 0) begin
        c = j + int'(ptr);
        if (c >= NUM_M) c = c - NUM_M;
      end
      if (!found && req_i[c]) begin
        found = 1'b1;
        win   = IDX_W'(c);
      end
    end
  end

  // Demultiplex the winner's request fields with constant slices.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (win == IDX_W'(i)) begin
        sel_we    = we_i[i];
        sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_M; i++) win_onehot[i] = (win_q == IDX_W'(i));
  end

  assign next_ptr    = (win_q == IDX_W'(NUM_M - 1)) ? '0 : win_q + 1'b1;
  assign status_word = {{(DATA_W-2){1'b0}}, serial_receiveComplete_i, serial_sendComplete_i};
  assign rx_word     = {{(DATA_W-8){1'b0}}, serial_dataRead_i[7:0]};
  // A write waits for the transmitter, a read waits for a received byte.
  assign ser_flag    = we_q ? serial_sendComplete_i : serial_receiveComplete_i;
  assign unused_rx_hi = ^serial_dataRead_i[DATA_W-1:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      win_q   <= '0;
      ptr     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_i) begin
            win_q   <= win;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            if (sel_addr == SER_STAT_ADDR) begin
              // Status writes are accepted and dropped.
              if (!sel_we) rdata_q <= status_word;
              state <= S_DONE;
            end else if (sel_addr == SER_DATA_ADDR) begin
              state <= S_SER_GO;
            end else begin
              cnt   <= CNT_W'(RAM_WAIT - 1);
              state <= S_RAM;
            end
          end
        end
        S_RAM: begin
          if (cnt == '0) begin
            if (!we_q) rdata_q <= ram_dataRead_i;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SER_GO: begin
          cnt   <= CNT_W'(SER_TIMEOUT);
          state <= S_SER_WAIT;
        end
        S_SER_WAIT: begin
          if (ser_flag) begin
            if (!we_q) rdata_q <= rx_word;
            state <= S_DONE;
          end else if (cnt == '0) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // The pointer moves past the master just served, so it gets the
          // lowest priority in the next round.
          if (ARB_MODE == 0) ptr <= next_ptr;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ram_enable_o       = (state == S_RAM);
  assign ram_readWrite_o    = we_q;
  assign ram_address_o      = addr_q;
  assign ram_dataWrite_o    = wdata_q;
  assign serial_enable_o    = (state == S_SER_GO);
  assign serial_readWrite_o = we_q;
  assign serial_dataWrite_o = wdata_q;
  assign ack_o              = (state == S_DONE) ? win_onehot : '0;
  assign stall_o            = req_i & ~ack_o;
  assign rdata_o            = rdata_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Two instances share every input except req:
// u[0] is round-robin and u[1] is fixed priority. Both use SER_TIMEOUT=15.
module tb_mem_arbiter;

  localparam int RW     = 2;
  localparam int SER_TO = 15;
  localparam logic [17:0] A_DATA = 18'h0BF00;
  localparam logic [17:0] A_STAT = 18'h0BF01;
  localparam int K_RAM = 0, K_STAT = 1, K_SER = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req [2];
  logic [1:0]  we_s = '0;
  logic [35:0] addr_s = '0;
  logic [31:0] wdata_s = '0;
  logic [15:0] ram_rd = '0;
  logic [15:0] ser_rd = '0;
  logic        sc = 1'b0;
  logic        rc = 1'b0;

  logic [15:0] rdata [2];
  logic [1:0]  ack [2];
  logic [1:0]  stall [2];
  logic        err [2];
  logic        ram_en [2];
  logic        ram_rw [2];
  logic [17:0] ram_addr [2];
  logic [15:0] ram_wd [2];
  logic        ser_en [2];
  logic        ser_rw [2];
  logic [15:0] ser_wd [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .NUM_M(2), .DATA_W(16), .ADDR_W(18), .ARB_MODE(g), .RAM_WAIT(RW),
      .SER_DATA_ADDR(A_DATA), .SER_STAT_ADDR(A_STAT), .SER_TIMEOUT(SER_TO)
    ) u (
      .clk(clk), .rst(rst), .req_i(req[g]), .we_i(we_s), .addr_i(addr_s),
      .wdata_i(wdata_s), .rdata_o(rdata[g]), .ack_o(ack[g]), .stall_o(stall[g]),
      .err_o(err[g]), .ram_enable_o(ram_en[g]), .ram_readWrite_o(ram_rw[g]),
      .ram_address_o(ram_addr[g]), .ram_dataWrite_o(ram_wd[g]),
      .ram_dataRead_i(ram_rd), .serial_enable_o(ser_en[g]),
      .serial_readWrite_o(ser_rw[g]), .serial_dataWrite_o(ser_wd[g]),
      .serial_dataRead_i(ser_rd), .serial_sendComplete_i(sc),
      .serial_receiveComplete_i(rc)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding access per instance,
  // tracked as cycles elapsed since its grant.
  int          m_busy [2] = '{0, 0};
  int          m_ack  [2] = '{0, 0};
  int          m_win  [2] = '{0, 0};
  int          m_kind [2] = '{0, 0};
  int          m_el   [2] = '{0, 0};
  int          m_ptr  [2] = '{0, 0};
  int          m_err  [2] = '{0, 0};
  logic        m_we   [2];
  logic [17:0] m_addr [2];
  logic [15:0] m_wd   [2];
  logic [15:0] m_data [2];

  task automatic model_step(input int k);
    int w;
    if (!rst) begin
      m_busy[k] = 0; m_ack[k] = 0; m_ptr[k] = 0; m_err[k] = 0; m_el[k] = 0;
      return;
    end
    if (m_ack[k] != 0) begin
      m_ack[k] = 0; m_busy[k] = 0;
      if (k == 0) m_ptr[k] = (m_win[k] + 1) % 2;
    end else if (m_busy[k] != 0) begin
      if (m_kind[k] == K_RAM) begin
        if (m_el[k] == RW) begin m_ack[k] = 1; m_data[k] = ram_rd; end
      end else if (m_kind[k] == K_SER && m_el[k] >= 2) begin
        if (m_we[k] ? sc : rc) begin
          m_ack[k] = 1; m_data[k] = {8'h00, ser_rd[7:0]};
        end else if (m_el[k] - 2 == SER_TO) begin
          m_ack[k] = 1; m_data[k] = 16'h0000; m_err[k] = 1;
        end
      end
      m_el[k]++;
    end else if (req[k] != 2'b00) begin
      if (k == 1) w = req[k][0] ? 0 : 1;
      else w = req[k][m_ptr[k]] ? m_ptr[k] : 1 - m_ptr[k];
      m_win[k] = w; m_busy[k] = 1; m_el[k] = 1;
      m_we[k] = we_s[w]; m_addr[k] = addr_s[w*18 +: 18]; m_wd[k] = wdata_s[w*16 +: 16];
      if (m_addr[k] == A_STAT) begin
        m_kind[k] = K_STAT; m_ack[k] = 1; m_data[k] = {14'd0, rc, sc};
      end else if (m_addr[k] == A_DATA) m_kind[k] = K_SER;
      else m_kind[k] = K_RAM;
    end
  endtask

  task automatic compare_inst(input int k);
    logic [1:0] ea;
    logic eram, eser;
    ea   = (m_busy[k] != 0 && m_ack[k] != 0) ? 2'(2'b01 << m_win[k]) : 2'b00;
    eram = m_busy[k] != 0 && m_ack[k] == 0 && m_kind[k] == K_RAM;
    eser = m_busy[k] != 0 && m_ack[k] == 0 && m_kind[k] == K_SER && m_el[k] == 1;
    check($sformatf("u%0d ack", k), 32'(ack[k]), 32'(ea));
    check($sformatf("u%0d stall", k), 32'(stall[k]), 32'(req[k] & ~ea));
    check($sformatf("u%0d err", k), 32'(err[k]), 32'(m_err[k]));
    check($sformatf("u%0d ram_en", k), 32'(ram_en[k]), 32'(eram));
    check($sformatf("u%0d ser_en", k), 32'(ser_en[k]), 32'(eser));
    if (eram) begin
      check($sformatf("u%0d ram_addr", k), 32'(ram_addr[k]), 32'(m_addr[k]));
      check($sformatf("u%0d ram_rw", k), 32'(ram_rw[k]), 32'(m_we[k]));
      check($sformatf("u%0d ram_wd", k), 32'(ram_wd[k]), 32'(m_wd[k]));
    end
    if (eser) begin
      check($sformatf("u%0d ser_rw", k), 32'(ser_rw[k]), 32'(m_we[k]));
      check($sformatf("u%0d ser_wd", k), 32'(ser_wd[k][7:0]), 32'(m_wd[k][7:0]));
    end
    if (ea != 2'b00 && !m_we[k])
      check($sformatf("u%0d rdata", k), 32'(rdata[k]), 32'(m_data[k]));
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
  end

  initial forever begin
    @(negedge clk);
    if (rst) for (int k = 0; k < 2; k++) compare_inst(k);
  end

  task automatic do_reset;
    rst = 1'b0;
    req[0] = 2'b00;
    req[1] = 2'b00;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  // One access by master m of instance k; lat counts cycles from the cycle
  // the request is first visible (0) to the ack cycle.
  task automatic txn(input int k, input int m, input logic w, input logic [17:0] a,
                     input logic [15:0] d, output int lat, output logic [15:0] rd,
                     output logic [1:0] av, output int ram_cnt, output int ser_cnt);
    lat = -1; rd = '0; av = '0; ram_cnt = 0; ser_cnt = 0;
    @(posedge clk); #1;
    we_s[m] = w; addr_s[m*18 +: 18] = a; wdata_s[m*16 +: 16] = d; req[k][m] = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (ram_en[k]) ram_cnt++;
      if (ser_en[k]) ser_cnt++;
      if (ack[k][m]) begin lat = c; rd = rdata[k]; av = ack[k]; break; end
    end
    @(posedge clk); #1;
    req[k][m] = 1'b0;
  endtask

  task automatic wait_ack(input int k, output int who);
    who = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack[k] != 2'b00) begin who = ack[k][1] ? 1 : 0; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rc_cnt, sc_cnt, who, n;
    logic [15:0] rd;
    logic [1:0]  av;
    req[0] = 2'b00;
    req[1] = 2'b00;

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset ack", 32'(ack[0]), 0);
    check("reset err", 32'(err[0]), 0);
    check("reset ram_en", 32'(ram_en[0]), 0);
    check("reset ser_en", 32'(ser_en[0]), 0);

    // Single RAM read
    ram_rd = 16'h1234;
    txn(0, 0, 1'b0, 18'h00100, 16'h0000, lat, rd, av, rc_cnt, sc_cnt);
    check("ram read latency", 32'(lat), 3);
    check("ram read enable cycles", 32'(rc_cnt), 2);
    check("ram read ack", 32'(av), 32'h1);
    check("ram read data", 32'(rd), 32'h1234);

    // Round-robin contention
    do_reset();
    ram_rd = 16'hBEEF;
    @(posedge clk); #1;
    we_s = 2'b00; addr_s = {18'h00300, 18'h00200}; req[0] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, who);
      check($sformatf("rr grant %0d", i), 32'(who), 32'(i % 2));
    end
    @(posedge clk); #1 req[0] = 2'b00;

    // Fixed priority
    do_reset();
    @(posedge clk); #1;
    addr_s = {18'h00300, 18'h00200}; req[1] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1, who);
      check($sformatf("fp grant %0d", i), 32'(who), 0);
    end
    @(posedge clk); #1 req[1][0] = 1'b0;
    wait_ack(1, who);
    check("fp grant after drop", 32'(who), 1);
    @(posedge clk); #1 req[1] = 2'b00;

    // Serial write, transmitter done 5 cycles after the start pulse
    sc = 1'b0; rc = 1'b0;
    fork
      txn(0, 1, 1'b1, A_DATA, 16'h0041, lat, rd, av, rc_cnt, sc_cnt);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (ser_en[0]) break;
        end
        repeat (5) @(posedge clk);
        #1 sc = 1'b1;
      end
    join
    sc = 1'b0;
    check("ser write latency", 32'(lat), 7);
    check("ser write pulses", 32'(sc_cnt), 1);
    check("ser write ack", 32'(av), 32'h2);
    check("ser write err", 32'(err[0]), 0);

    // Status read
    rc = 1'b1; sc = 1'b0;
    txn(0, 0, 1'b0, A_STAT, 16'h0000, lat, rd, av, rc_cnt, sc_cnt);
    rc = 1'b0;
    check("status latency", 32'(lat), 1);
    check("status data", 32'(rd), 32'h0002);

    // Serial read timeout, then err stays set
    ser_rd = 16'h00C3;
    txn(0, 0, 1'b0, A_DATA, 16'h0000, lat, rd, av, rc_cnt, sc_cnt);
    check("timeout latency", 32'(lat), 18);
    check("timeout data", 32'(rd), 0);
    check("timeout err", 32'(err[0]), 1);
    txn(0, 1, 1'b1, 18'h00600, 16'h5A5A, lat, rd, av, rc_cnt, sc_cnt);
    check("post-timeout ram latency", 32'(lat), 3);
    check("err sticky", 32'(err[0]), 1);

    // Asynchronous reset in the middle of a RAM access
    @(posedge clk); #1;
    we_s = 2'b00; addr_s[18 +: 18] = 18'h00500; req[0][1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid-ram enable", 32'(ram_en[0]), 1);
    #2 rst = 1'b0;
    #1;
    check("async reset ram_en", 32'(ram_en[0]), 0);
    check("async reset ack", 32'(ack[0]), 0);
    check("async reset err", 32'(err[0]), 0);
    req[0] = 2'b00;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[0] != 2'b00) n++;
    end
    #1 rst = 1'b1;
    check("no ack across reset", 32'(n), 0);
    @(posedge clk); #1;
    addr_s = {18'h00700, 18'h00800}; req[0] = 2'b11;
    wait_ack(0, who);
    check("first grant after reset", 32'(who), 0);
    @(posedge clk); #1 req[0] = 2'b00;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
